// File: rtl/kianv_mem_responder.sv
// Native-bus memory responder: word-organised RAM with byte strobes and
// programmable wait states, decoding its own address window.
module kianv_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            ram_we_c;
    logic            unused_addr_bits;

    logic [DW-1:0]   ram_q [DEPTH_WORDS];

    // Window decode: only the bits above the RAM index take part.
    assign sel = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

    // Byte-offset bits never select anything inside a word.
    assign unused_addr_bits = ^mem_addr[1:0];

    // Next-state, request latching and registered-output precompute.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid && sel) begin
                    idx_d   = mem_addr[AW+1:2];
                    wstrb_d = mem_wstrb;
                    wdata_d = mem_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is captured on the edge that enters RESP and then held.
        if ((state_d == ST_RESP) && (wstrb_d == '0)) begin
            rdata_d = ram_q[idx_d];
        end

        ready_d = (state_d == ST_RESP);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // The edge that ends RESP commits the write; a reset before it aborts it.
    assign ram_we_c = (state_q == ST_RESP) && (wstrb_q != '0);

    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb_q[b]) begin
                    ram_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_kianv_mem_responder.sv
// Self-checking bench for kianv_mem_responder: three instances with different
// wait states / windows, a directed vector table and multi-cycle sequences.
module tb_kianv_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        resetn;
    logic [2:0]        valid;
    logic [2:0]        ready;
    logic [2:0][3:0]   wstrb;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  wdata;
    logic [2:0][31:0]  rdata;
    logic [2:0]        sel;
    logic [2:0]        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_lat [3] = '{3, 1, 4};

    kianv_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .resetn(resetn[0]), .mem_valid(valid[0]), .mem_ready(ready[0]),
        .mem_wstrb(wstrb[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .sel(sel[0]), .busy(busy[0]));

    kianv_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .resetn(resetn[1]), .mem_valid(valid[1]), .mem_ready(ready[1]),
        .mem_wstrb(wstrb[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .sel(sel[1]), .busy(busy[1]));

    kianv_mem_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(16), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .resetn(resetn[2]), .mem_valid(valid[2]), .mem_ready(ready[2]),
        .mem_wstrb(wstrb[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_rdata(rdata[2]), .sel(sel[2]), .busy(busy[2]));

    typedef struct {
        int          inst;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction from a falling edge; latency counted in cycles after accept.
    task automatic xact(input int k, input logic [3:0] ws, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic rdy_after);
        valid[k] = 1'b1;
        wstrb[k] = ws;
        addr[k]  = a;
        wdata[k] = d;
        lat      = 99;
        rd       = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                lat = c;
                rd  = rdata[k];
                break;
            end
        end
        valid[k] = 1'b0;
        @(negedge clk);
        rdy_after = ready[k];
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        rdy_after;
        logic [31:0] b2b_exp [4];
        int          idx;
        logic        any_r, any_b;

        vecs.push_back('{0, 4'hF, 32'h0000_0010, 32'h4444_4444, 32'h0000_0000});
        vecs.push_back('{0, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000});
        vecs.push_back('{0, 4'h2, 32'h0000_0020, 32'h0000_5500, 32'h0000_0000});
        vecs.push_back('{0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_55EF});
        vecs.push_back('{0, 4'hF, 32'h0000_0024, 32'h1234_5678, 32'hDEAD_55EF});
        vecs.push_back('{0, 4'h9, 32'h0000_0024, 32'hAABB_CCDD, 32'hDEAD_55EF});
        vecs.push_back('{0, 4'h0, 32'h0000_0024, 32'h0000_0000, 32'hAA34_56DD});
        vecs.push_back('{0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h4444_4444});
        vecs.push_back('{1, 4'hF, 32'h0000_0000, 32'hA0A0_A0A0, 32'h0000_0000});
        vecs.push_back('{1, 4'hF, 32'h0000_0004, 32'hB1B1_B1B1, 32'h0000_0000});
        vecs.push_back('{1, 4'hF, 32'h0000_0008, 32'hC2C2_C2C2, 32'h0000_0000});
        vecs.push_back('{1, 4'hF, 32'h0000_000C, 32'hD3D3_D3D3, 32'h0000_0000});
        vecs.push_back('{1, 4'h4, 32'h0000_0004, 32'h00EE_0000, 32'h0000_0000});
        vecs.push_back('{1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'hB1EE_B1B1});
        vecs.push_back('{2, 4'hF, 32'h1000_0008, 32'h1122_3344, 32'h0000_0000});
        vecs.push_back('{2, 4'hF, 32'h1000_0004, 32'h7777_7777, 32'h0000_0000});
        vecs.push_back('{2, 4'hF, 32'h1000_0000, 32'h0F0F_0F0F, 32'h0000_0000});
        vecs.push_back('{2, 4'hF, 32'h1000_003F, 32'h5A5A_5A5A, 32'h0000_0000});
        vecs.push_back('{2, 4'h0, 32'h1000_0000, 32'h0000_0000, 32'h0F0F_0F0F});
        vecs.push_back('{2, 4'h0, 32'h1000_003C, 32'h0000_0000, 32'h5A5A_5A5A});
        vecs.push_back('{2, 4'h0, 32'h1000_000B, 32'h0000_0000, 32'h1122_3344});

        resetn = '0;
        valid  = '0;
        wstrb  = '0;
        addr   = '0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready[%0d]", k), 32'(ready[k]), 32'h0);
            check($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
            check($sformatf("reset_busy[%0d]", k), 32'(busy[k]), 32'h0);
        end
        resetn = '1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            xact(vecs[i].inst, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, lat, rd, rdy_after);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat[vecs[i].inst]));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_ready_one_cycle", i), 32'(rdy_after), 32'h0);
        end

        // WAIT_STATES=2 read straight after reset release, cycle by cycle.
        resetn[0] = 1'b0;
        #1;
        check("ws2_rst_rdata", rdata[0], 32'h0);
        check("ws2_rst_ready", 32'(ready[0]), 32'h0);
        @(negedge clk);
        resetn[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b1;
        wstrb[0] = 4'h0;
        addr[0]  = 32'h0000_0010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("ws2_busy_c%0d", c), 32'(busy[0]), 32'((c <= 3) ? 1 : 0));
            check($sformatf("ws2_ready_c%0d", c), 32'(ready[0]), 32'((c == 3) ? 1 : 0));
            if (c == 3) begin
                check("ws2_rdata", rdata[0], 32'h4444_4444);
                valid[0] = 1'b0;
            end
        end

        // WAIT_STATES=0 back-to-back reads with valid held throughout.
        b2b_exp = '{32'hA0A0_A0A0, 32'hB1EE_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
        idx = 0;
        valid[1] = 1'b1;
        wstrb[1] = 4'h0;
        addr[1]  = 32'h0000_0000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), 32'(ready[1]), 32'(c % 2));
            if (ready[1] && idx < 4) begin
                check($sformatf("b2b_rdata%0d", idx), rdata[1], b2b_exp[idx]);
                idx++;
                if (idx < 4) addr[1] = 32'(idx * 4);
                else         valid[1] = 1'b0;
            end
        end
        valid[1] = 1'b0;

        // Out-of-window request is ignored, then an in-window one is served.
        valid[2] = 1'b1;
        wstrb[2] = 4'h0;
        addr[2]  = 32'h2000_0000;
        #1;
        check("oow_sel", 32'(sel[2]), 32'h0);
        any_r = 1'b0;
        any_b = 1'b0;
        repeat (50) begin
            @(negedge clk);
            any_r = any_r | ready[2];
            any_b = any_b | busy[2];
        end
        check("oow_no_ready", 32'(any_r), 32'h0);
        check("oow_no_busy", 32'(any_b), 32'h0);
        addr[2] = 32'h1000_0004;
        #1;
        check("inwin_sel", 32'(sel[2]), 32'h1);
        xact(2, 4'h0, 32'h1000_0004, 32'h0, lat, rd, rdy_after);
        check("inwin_latency", 32'(lat), 32'd4);
        check("inwin_rdata", rd, 32'h7777_7777);

        // Reset during WAIT aborts the write.
        valid[2] = 1'b1;
        wstrb[2] = 4'hF;
        addr[2]  = 32'h1000_0008;
        wdata[2] = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy[2]), 32'h1);
        resetn[2] = 1'b0;
        valid[2]  = 1'b0;
        #1;
        check("abort_ready", 32'(ready[2]), 32'h0);
        check("abort_rdata", rdata[2], 32'h0);
        check("abort_busy", 32'(busy[2]), 32'h0);
        @(negedge clk);
        resetn[2] = 1'b1;
        @(negedge clk);
        xact(2, 4'h0, 32'h1000_0008, 32'h0, lat, rd, rdy_after);
        check("abort_latency", 32'(lat), 32'd4);
        check("abort_old_data", rd, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kianv_mem_responder.md
Name: kianv_mem_responder

Overview:
- Native-bus memory responder: the target end of the core's mem_valid/mem_ready/mem_wstrb/mem_addr/mem_wdata/mem_rdata initiator interface.
- Wraps a word-organised on-chip RAM with byte-write strobes and a programmable number of wait states.
- Decodes its own address window and drives a select flag so the SoC bus mux can route mem_ready/mem_rdata from multiple responders.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to DEPTH_WORDS*4.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, 16..65536; AW = log2(DEPTH_WORDS).
- WAIT_STATES, 1, extra cycles before mem_ready; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- mem_valid  input  1  request valid, held by initiator until mem_ready.
- mem_ready  output  1  one-cycle response strobe.
- mem_wstrb  input  4  byte write enables; 4'b0000 = read.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data, byte lanes per mem_wstrb.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- sel  output  1  combinational window hit: mem_addr[31:AW+2] == BASE_ADDR[31:AW+2].
- busy  output  1  high in WAIT or RESP.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; mem_ready=0, mem_rdata=32'h0, busy=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Accept when mem_valid & sel.
  - On accept, latch word index mem_addr[AW+1:2], mem_wstrb and mem_wdata.
  - If WAIT_STATES=0, go to RESP; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement counter each cycle; at 0, go to RESP. Bus inputs are ignored here; the latched copies are used.
- RESP:
  - mem_ready=1 for exactly this one cycle; next state IDLE.
  - Write (latched wstrb != 0): the clock edge that ends RESP updates only the enabled byte lanes of RAM[idx].
  - Read (latched wstrb = 0): mem_rdata shows RAM[idx] throughout RESP. The RAM read is registered on the edge entering RESP.
- Latency:
  - mem_ready is high in cycle N+1+WAIT_STATES, where N is the accept cycle (first cycle with mem_valid & sel in IDLE).
  - With WAIT_STATES=0, a request presented in cycle 0 gets mem_ready in cycle 1.
- mem_rdata:
  - Changes only on completed reads and holds its value otherwise, including across writes and idle cycles.
  - After a write it keeps the previous read value.
- Back-to-back: IDLE accepts in the cycle right after RESP. The initiator must drop mem_valid or present a new request in the cycle after mem_ready. A request still held then is treated as new.
- Out-of-window (sel=0): request never accepted, no mem_ready, no state change. Timeout and decode errors are owned by the bus fabric.
- mem_valid dropped by the initiator mid-transaction (protocol violation): the transaction still completes and a write still commits.
- Reset mid-operation: transaction aborted. No RAM write occurs unless the RESP-ending edge already happened. mem_ready deasserts immediately.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Only the RAM index register and wait counter are AW- and 4-bit wide. Address bits above AW+1 take part only in sel.

Test Plan:
- Reset release, WAIT_STATES=2: read of 0x0000_0010 presented at cycle 0 -> mem_ready exactly at cycle 3 for one cycle, mem_rdata=RAM[4]; busy high cycles 1-3.
- Write 0x0000_0020 wdata=32'hDEADBEEF wstrb=4'b1111, then wstrb=4'b0010 wdata=32'h0000_5500, then read -> mem_rdata=32'hDEAD55EF; mem_rdata unchanged during both writes.
- WAIT_STATES=0: four back-to-back reads at 0x0,0x4,0x8,0xC with valid held continuously and address advanced after each ready -> mem_ready high every other cycle, data matches preloaded words.
- BASE_ADDR=32'h1000_0000: read at 32'h2000_0000 -> sel=0, no mem_ready for 50 cycles, busy stays 0; read at 32'h1000_0004 -> sel=1, response normal.
- Write 32'hCAFEF00D with WAIT_STATES=3, resetn pulsed low in WAIT -> mem_ready=0 and mem_rdata=0 immediately; after reset, read of same address returns the old contents.
- Write to the last word (DEPTH_WORDS-1) with a non-zero mem_addr[1:0] -> the same word is written as with [1:0]=0, and word 0 is unchanged.
